// File: rtl/frame_similarity_engine_if.sv
// rtl/frame_similarity_engine_if.sv - request/result bundle between the GAN output path and the similarity scorer
//
// Purpose: carries the run request, the two flat frames and the scored
// results between a requester (master) and frame_similarity_engine (slave).
// Signals:
//   start          master->slave  single-cycle run request
//   frame_a_flat   master->slave  generated frame, pixel i at [(i+1)*W-1 -: W]
//   frame_b_flat   master->slave  reference frame, same packing
//   busy           slave->master  run in progress
//   done           slave->master  one-cycle pulse, results valid
//   sum_abs        slave->master  sum of per-pixel absolute differences
//   avg_abs        slave->master  floor(sum_abs / PIXEL_COUNT)
//   max_abs        slave->master  largest per-pixel absolute difference
//   pass           slave->master  avg_abs within the pass limit
//   mismatch_count slave->master  pixels that differ (0 when the counter is not built)
interface frame_similarity_engine_if #(
  parameter int PIXEL_COUNT = 784,
  parameter int PIXEL_WIDTH = 16
);
  localparam int SUM_W = PIXEL_WIDTH + $clog2(PIXEL_COUNT + 1);
  localparam int CNT_W = $clog2(PIXEL_COUNT + 1);

  logic                               start;
  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] frame_a_flat;
  logic [PIXEL_WIDTH*PIXEL_COUNT-1:0] frame_b_flat;
  logic                               busy;
  logic                               done;
  logic [SUM_W-1:0]                   sum_abs;
  logic [PIXEL_WIDTH-1:0]             avg_abs;
  logic [PIXEL_WIDTH-1:0]             max_abs;
  logic                               pass;
  logic [CNT_W-1:0]                   mismatch_count;

  modport master (
    output start, frame_a_flat, frame_b_flat,
    input  busy, done, sum_abs, avg_abs, max_abs, pass, mismatch_count
  );

  modport slave (
    input  start, frame_a_flat, frame_b_flat,
    output busy, done, sum_abs, avg_abs, max_abs, pass, mismatch_count
  );
endinterface

// File: rtl/frame_similarity_engine.sv
// rtl/frame_similarity_engine.sv - pixel-serial absolute-difference scorer for two latched frames
//
// Purpose: on start, latches both frames, walks them one pixel per cycle
// accumulating sum and max of |a-b|, then divides the sum by PIXEL_COUNT with
// a one-bit-per-cycle restoring divider and publishes sum/avg/max/pass.
// Optional feature macro: FRAME_SIMILARITY_MISMATCH_COUNT_EN adds a count of
// differing pixels; without it mismatch_count is tied to 0.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   sim_bus  frame_similarity_engine_if.slave (request, frames, results)
module frame_similarity_engine #(
  parameter int PIXEL_COUNT    = 784,
  parameter int PIXEL_WIDTH    = 16,
  parameter int PASS_AVG_LIMIT = 16
) (
  input logic                      clk,
  input logic                      rst,
  frame_similarity_engine_if.slave sim_bus
);
  localparam int SUM_W   = PIXEL_WIDTH + $clog2(PIXEL_COUNT + 1);
  localparam int IDX_W   = $clog2(PIXEL_COUNT);
  localparam int REM_W   = $clog2(PIXEL_COUNT) + 1;
  localparam int STEP_W  = $clog2(SUM_W + 1);
  localparam int FRAME_W = PIXEL_WIDTH * PIXEL_COUNT;

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [STEP_W-1:0]      LAST_STEP = STEP_W'(SUM_W);
  localparam logic [REM_W-1:0]       DIVISOR   = REM_W'(PIXEL_COUNT);
  localparam logic [PIXEL_WIDTH-1:0] AVG_LIMIT = PIXEL_WIDTH'(PASS_AVG_LIMIT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DIVIDE = 2'd2} state_t;

  state_t state_q, state_d;

  logic busy, load_en, scan_en, div_en, finish_en;

  logic [FRAME_W-1:0]     buf_a_q, buf_b_q;
  logic [IDX_W-1:0]       idx_q;
  logic [STEP_W-1:0]      step_q;
  logic [SUM_W-1:0]       sum_q;
  logic [PIXEL_WIDTH-1:0] max_q;
  logic [SUM_W-1:0]       div_q;
  logic [REM_W-2:0]       rem_q;

  logic [SUM_W-1:0]       sum_abs_q;
  logic [PIXEL_WIDTH-1:0] avg_abs_q, max_abs_q;
  logic                   pass_q, done_q;

  logic [PIXEL_WIDTH-1:0] pix_a, pix_b, abs_diff;
  logic [PIXEL_WIDTH:0]   diff;
  logic [SUM_W-1:0]       sum_next;
  logic [REM_W-1:0]       rem_shift;
  logic                   rem_ge;
  logic                   last_scan, last_step;

  assign last_scan = (idx_q == LAST_IDX);
  assign last_step = (step_q == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (sim_bus.start) state_d = S_SCAN;
      S_SCAN:   if (last_scan)     state_d = S_DIVIDE;
      S_DIVIDE: if (last_step)     state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // DIVIDE runs SUM_W quotient steps, then spends one more edge publishing results.
  always_comb begin
    busy      = 1'b0;
    load_en   = 1'b0;
    scan_en   = 1'b0;
    div_en    = 1'b0;
    finish_en = 1'b0;
    case (state_q)
      S_IDLE:   load_en = sim_bus.start;
      S_SCAN: begin
        busy    = 1'b1;
        scan_en = 1'b1;
      end
      S_DIVIDE: begin
        busy      = 1'b1;
        finish_en = last_step;
        div_en    = ~last_step;
      end
      default: ;
    endcase
  end

  // Buffers shift right so the current pixel always sits in the low word.
  assign pix_a    = buf_a_q[PIXEL_WIDTH-1:0];
  assign pix_b    = buf_b_q[PIXEL_WIDTH-1:0];
  assign diff     = {1'b0, pix_a} - {1'b0, pix_b};
  assign abs_diff = diff[PIXEL_WIDTH] ? (~diff[PIXEL_WIDTH-1:0] + 1'b1) : diff[PIXEL_WIDTH-1:0];
  assign sum_next = sum_q + {{(SUM_W-PIXEL_WIDTH){1'b0}}, abs_diff};

  // Restoring division: the dividend shifts out of div_q's MSB while the
  // quotient bits shift into its LSB, so div_q ends up holding the quotient.
  assign rem_shift = {rem_q, div_q[SUM_W-1]};
  assign rem_ge    = (rem_shift >= DIVISOR);

  always_ff @(posedge clk) begin
    if (load_en) begin
      buf_a_q <= sim_bus.frame_a_flat;
      buf_b_q <= sim_bus.frame_b_flat;
    end else if (scan_en) begin
      buf_a_q <= {{PIXEL_WIDTH{1'b0}}, buf_a_q[FRAME_W-1:PIXEL_WIDTH]};
      buf_b_q <= {{PIXEL_WIDTH{1'b0}}, buf_b_q[FRAME_W-1:PIXEL_WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      step_q    <= '0;
      sum_q     <= '0;
      max_q     <= '0;
      div_q     <= '0;
      rem_q     <= '0;
      sum_abs_q <= '0;
      avg_abs_q <= '0;
      max_abs_q <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish_en;
      if (load_en) begin
        idx_q <= '0;
        sum_q <= '0;
        max_q <= '0;
      end else if (scan_en) begin
        idx_q <= idx_q + 1'b1;
        sum_q <= sum_next;
        if (abs_diff > max_q) max_q <= abs_diff;
        if (last_scan) begin
          div_q  <= sum_next;
          rem_q  <= '0;
          step_q <= '0;
        end
      end else if (div_en) begin
        rem_q  <= rem_ge ? (REM_W-1)'(rem_shift - DIVISOR) : rem_shift[REM_W-2:0];
        div_q  <= {div_q[SUM_W-2:0], rem_ge};
        step_q <= step_q + 1'b1;
      end
      if (finish_en) begin
        sum_abs_q <= sum_q;
        avg_abs_q <= div_q[PIXEL_WIDTH-1:0];
        max_abs_q <= max_q;
        pass_q    <= (div_q[PIXEL_WIDTH-1:0] <= AVG_LIMIT);
      end
    end
  end

`ifdef FRAME_SIMILARITY_MISMATCH_COUNT_EN
  localparam int CNT_W = $clog2(PIXEL_COUNT + 1);

  logic [CNT_W-1:0] cnt_q, mismatch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      mismatch_q <= '0;
    end else begin
      if (load_en)                        cnt_q <= '0;
      else if (scan_en && (pix_a != pix_b)) cnt_q <= cnt_q + 1'b1;
      if (finish_en) mismatch_q <= cnt_q;
    end
  end

  assign sim_bus.mismatch_count = mismatch_q;
`else
  assign sim_bus.mismatch_count = '0;
`endif

  assign sim_bus.busy    = busy;
  assign sim_bus.done    = done_q;
  assign sim_bus.sum_abs = sum_abs_q;
  assign sim_bus.avg_abs = avg_abs_q;
  assign sim_bus.max_abs = max_abs_q;
  assign sim_bus.pass    = pass_q;
endmodule

// File: doc/frame_similarity_engine.md
# frame_similarity_engine

Sequential hardware scorer for the GAN output path: on `start` it latches two 28x28 Q8.8 frames (generated frame and reference sample), walks them one pixel per cycle, and produces the sum, average and maximum absolute pixel difference plus a pass flag. It sits directly downstream of `gan_comb_top`, consuming `generated_frame_flat`/`sample_flat` on `generated_frame_valid`. It replaces the bench-side similarity loop with synthesizable logic for on-chip self-check.

## Interface
- `PIXEL_COUNT`, 784, pixels per frame (>=2).
- `PIXEL_WIDTH`, 16, bits per pixel; words are compared as unsigned.
- `PASS_AVG_LIMIT`, 16, `pass` requires `avg_abs <= PASS_AVG_LIMIT`.
- Derived, not overridable: `SUM_W = PIXEL_WIDTH + $clog2(PIXEL_COUNT+1)`, 26 at defaults.
- `clk` in 1 rising-edge clock.
- `rst` in 1 asynchronous, active-high reset.
- `start` in 1 single-cycle request; sampled only in IDLE.
- `frame_a_flat` in PIXEL_WIDTH*PIXEL_COUNT generated frame; pixel i at `[(i+1)*W-1 -: W]`.
- `frame_b_flat` in PIXEL_WIDTH*PIXEL_COUNT reference frame, same packing.
- `busy` out 1 high from the start edge until the done edge.
- `done` out 1 one-cycle pulse when results are valid.
- `sum_abs` out SUM_W sum of abs(a[i]-b[i]).
- `avg_abs` out PIXEL_WIDTH floor(sum_abs / PIXEL_COUNT).
- `max_abs` out PIXEL_WIDTH largest per-pixel abs difference.
- `pass` out 1 `avg_abs <= PASS_AVG_LIMIT`.
- `mismatch_count` out $clog2(PIXEL_COUNT+1) count of pixels with a != b (see Configuration).

## Operation
- States: IDLE -> SCAN -> DIVIDE -> IDLE.
- IDLE: on `start`=1, copy both frames into internal buffers, clear the accumulators and index, set `busy`, go to SCAN. Input frames may change after the start edge without affecting the result.
- SCAN: one pixel per cycle at index 0..PIXEL_COUNT-1.
  - diff = a - b computed at PIXEL_WIDTH+1 bits, then abs taken, giving PIXEL_WIDTH bits.
  - Add diff to sum (SUM_W bits; cannot overflow by construction).
  - Update max when diff > max. Ties keep the existing value.
  - Index PIXEL_COUNT-1 is the last cycle; then go to DIVIDE.
- DIVIDE: restoring unsigned divide of sum by the constant PIXEL_COUNT, one quotient bit per cycle, SUM_W cycles, MSB first. Quotient is truncated to PIXEL_WIDTH; the upper bits are always zero.
- Completion, on the edge after the last divide step:
  - Register `sum_abs`, `avg_abs`, `max_abs`, `pass` and `mismatch_count`.
  - Pulse `done` for one cycle, clear `busy`, return to IDLE.
- Result outputs hold their values until the next completion. They do not change during a later run.
- `start` while busy is ignored. It is not queued.

## Timing
- Reset (async assert, synchronous-safe release): state IDLE; `busy`, `done`, `pass` = 0; `sum_abs`, `avg_abs`, `max_abs`, `mismatch_count` = 0; internal buffers need not be cleared.
- Let E0 be the edge that samples `start`=1:
  - `busy` is high after E0.
  - SCAN occupies edges E1..E(PIXEL_COUNT).
  - DIVIDE occupies the next SUM_W edges.
  - `done`=1 and results are valid after edge E(PIXEL_COUNT+SUM_W+1). This is E811 at defaults.
  - `busy` falls on that same edge.
- Back-to-back: `start` in the `done` cycle is accepted, and the new run begins on the next edge.
- Reset mid-SCAN or mid-DIVIDE aborts immediately to the reset values. No `done` is produced.
- Throughput: one frame per PIXEL_COUNT+SUM_W+1 cycles.

## Configuration
- `FRAME_SIMILARITY_MISMATCH_COUNT_EN` defined:
  - SCAN also increments a counter when a[i] != b[i].
  - The counter is registered to `mismatch_count` at completion.
- Macro not defined:
  - The counter logic is absent and `mismatch_count` is tied to 0.
  - All other behaviour, including `pass` and latency, is identical.
- `pass` never depends on `mismatch_count`.

## Test plan
- Identical frames (all 0x0080), start -> `done` exactly 811 cycles after the start edge; `sum_abs`=0, `avg_abs`=0, `max_abs`=0, `pass`=1, `mismatch_count`=0.
- a all 0x0100, b all 0x0000 -> `sum_abs`=200704, `avg_abs`=256, `max_abs`=256, `pass`=0, `mismatch_count`=784 with the macro and 0 without it.
- a all 0x0000 except pixel 783 = 0xFFFF, b all 0x0000 -> `sum_abs`=65535, `avg_abs`=83, `max_abs`=65535, `pass`=0, `mismatch_count`=1 with the macro.
- a all 0x0000, b with pixels 0..9 = 0x0500 (b > a, unsigned wrap check) -> `sum_abs`=12800, `avg_abs`=16, `max_abs`=0x0500, `pass`=1.
- Change both frames one cycle after start, and pulse `start` again at cycle 100 -> results match the latched frames, only one `done` occurs, and it arrives at cycle 811.
- Assert `rst` at cycle 400 of a run, then release and start fresh with identical frames -> no `done` from the aborted run, all outputs read 0 during reset, and the new run completes after 811 cycles with `sum_abs`=0.
